// File: rtl/i2c_pkg.sv
// Shared state encoding and protocol constants for the I2C target write receiver.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } i2c_rx_state_t;

  localparam logic I2C_RW_WRITE  = 1'b0;
  localparam int   I2C_BYTE_BITS = 8;

endpackage

// File: rtl/i2c_pin_cond.sv
// Pin conditioner: SYNC_STAGES synchroniser, optional I2C_GLITCH_FILTER_EN filter, registered edge detect.
// Latency pin->level/rise/fall is SYNC_STAGES+1 clk (+FILTER_LEN with the filter); no backpressure.
module i2c_pin_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_cfg
    $error("i2c_pin_cond: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic                   cond;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], pin};
  end

  assign synced = sync[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] run_cnt;
  logic          filt;

  // The filtered level only follows once FILTER_LEN samples in a row disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0;
      filt    <= 1'b1;
    end else if (synced == filt) begin
      run_cnt <= '0;
    end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
      run_cnt <= '0;
      filt    <= synced;
    end else begin
      run_cnt <= run_cnt + CW'(1);
    end
  end

  assign cond = filt;
`else
  assign cond = synced;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      prev <= cond;
      rise <= cond & ~prev;
      fall <= ~cond & prev;
    end
  end

  // Level comes from the same flop stage as the edge strobes so they stay aligned.
  assign level = prev;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C target write receiver: START/STOP detect, 7-bit address match, ACK via open-drain, bytes out on valid/ready.
// Pin-to-event latency SYNC_STAGES+1 clk; a byte completing while rx_valid is unconsumed is NACKed (overrun). Option: I2C_GLITCH_FILTER_EN.
module i2c_target_rx #(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       addr_hit,
  output logic       bus_busy,
  output logic       overrun
);

  import i2c_pkg::*;

  localparam int CNT_W = $clog2(I2C_BYTE_BITS);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;
  logic start_evt, stop_evt, accept;

  i2c_rx_state_t              state, state_n;
  logic [CNT_W-1:0]           bit_cnt, bit_cnt_n;
  logic                       byte_full, byte_full_n;
  logic [I2C_BYTE_BITS-1:0]   shift, shift_n;
  logic [7:0]                 rx_data_n;
  logic                       sda_oe_n, rx_valid_n, addr_hit_n, bus_busy_n, overrun_n;

  i2c_pin_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(clk), .rst(rst), .pin(scl_in),
    .level(scl_level), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_pin_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(clk), .rst(rst), .pin(sda_in),
    .level(sda_level), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_evt = sda_fall & scl_level;
  assign stop_evt  = sda_rise & scl_level;
  assign accept    = ~rx_valid | rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      byte_full <= 1'b0;
      shift     <= '0;
      rx_data   <= '0;
      sda_oe    <= 1'b0;
      rx_valid  <= 1'b0;
      addr_hit  <= 1'b0;
      bus_busy  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      byte_full <= byte_full_n;
      shift     <= shift_n;
      rx_data   <= rx_data_n;
      sda_oe    <= sda_oe_n;
      rx_valid  <= rx_valid_n;
      addr_hit  <= addr_hit_n;
      bus_busy  <= bus_busy_n;
      overrun   <= overrun_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    byte_full_n = byte_full;
    shift_n     = shift;
    rx_data_n   = rx_data;
    sda_oe_n    = sda_oe;
    rx_valid_n  = rx_valid & ~rx_ready;
    addr_hit_n  = addr_hit;
    bus_busy_n  = bus_busy;
    overrun_n   = 1'b0;

    if (stop_evt) begin
      state_n     = IDLE;
      bit_cnt_n   = '0;
      byte_full_n = 1'b0;
      sda_oe_n    = 1'b0;
      addr_hit_n  = 1'b0;
      bus_busy_n  = 1'b0;
    end else if (start_evt) begin
      state_n     = i2c_pkg::ADDR;
      bit_cnt_n   = '0;
      byte_full_n = 1'b0;
      sda_oe_n    = 1'b0;
      addr_hit_n  = 1'b0;
      bus_busy_n  = 1'b1;
    end else begin
      case (state)
        i2c_pkg::ADDR, DATA: begin
          // Bits are taken on SCL rise; the completed byte is acted on at the following fall.
          if (scl_rise && !byte_full) begin
            shift_n   = {shift[I2C_BYTE_BITS-2:0], sda_level};
            bit_cnt_n = bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(I2C_BYTE_BITS - 1)) byte_full_n = 1'b1;
          end else if (scl_fall && byte_full) begin
            byte_full_n = 1'b0;
            if (state == i2c_pkg::ADDR) begin
              if (shift[7:1] == ADDR && shift[0] == I2C_RW_WRITE) begin
                sda_oe_n   = 1'b1;
                addr_hit_n = 1'b1;
                state_n    = ADDR_ACK;
              end else begin
                state_n    = IGNORE;
              end
            end else if (accept) begin
              rx_data_n  = shift;
              rx_valid_n = 1'b1;
              sda_oe_n   = 1'b1;
              state_n    = DATA_ACK;
            end else begin
              overrun_n  = 1'b1;
              sda_oe_n   = 1'b0;
              state_n    = IGNORE;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = DATA;
          end
        end
        IGNORE:  sda_oe_n = 1'b0;
        IDLE:    ;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: 400 kHz master model on a wired-AND SDA, behavioural expectation model, randomized transfers.
module tb_i2c_target_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       addr_hit, bus_busy, overrun;

  int checks = 0;
  int passed = 0;
  int ovr_cnt = 0;
  int oe_cnt = 0;

  // Expectation model: what the consumer should see, derived from protocol rules only.
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_target_rx #(.ADDR(7'h42), .SYNC_STAGES(2), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .addr_hit(addr_hit), .bus_busy(bus_busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun === 1'b1) ovr_cnt++;
    if (sda_oe === 1'b1) oe_cnt++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    wait_clk(20); sda_m = 1'b0; wait_clk(125); scl_m = 1'b0;
  endtask

  task automatic i2c_rep_start();
    wait_clk(62); sda_m = 1'b1; wait_clk(63); scl_m = 1'b1;
    wait_clk(125); sda_m = 1'b0; wait_clk(125); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(62); sda_m = 1'b0; wait_clk(63); scl_m = 1'b1;
    wait_clk(125); sda_m = 1'b1; wait_clk(125);
  endtask

  task automatic send_bit(input logic b, output logic oe_mid);
    wait_clk(62); sda_m = b; wait_clk(63); scl_m = 1'b1;
    wait_clk(62); oe_mid = sda_oe; wait_clk(63); scl_m = 1'b0;
  endtask

  // ack = target held SDA low during the middle of the 9th SCL high phase.
  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) send_bit(b[i], dummy);
    send_bit(1'b1, ack);
  endtask

  task automatic consume(input logic [7:0] exp, input string name);
    int n = 0;
    while (rx_valid !== 1'b1 && n < 50) begin wait_clk(1); n++; end
    checks++;
    if (rx_valid !== 1'b1) $display("FAIL %s_valid: rx_valid=%b required 1", name, rx_valid);
    else passed++;
    checks++;
    if (rx_data !== exp) $display("FAIL %s_data: rx_data=%h required %h", name, rx_data, exp);
    else passed++;
    rx_ready = 1'b1; wait_clk(1); rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) $display("FAIL %s_clear: rx_valid=%b required 0", name, rx_valid);
    else passed++;
    m_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wait_clk(5);
    checks++;
    if ({sda_oe, rx_valid, addr_hit, bus_busy, overrun, rx_data} !== 13'h0)
      $display("FAIL reset_outputs: oe=%b v=%b hit=%b busy=%b ovr=%b data=%h required all 0",
               sda_oe, rx_valid, addr_hit, bus_busy, overrun, rx_data);
    else passed++;
    rst = 1'b0; wait_clk(10);
  endtask

  task automatic test_basic_write();
    logic ack;
    i2c_start(); wait_clk(5);
    checks++;
    if (bus_busy !== 1'b1) $display("FAIL basic_busy: bus_busy=%b required 1", bus_busy); else passed++;
    write_byte({7'h42, 1'b0}, ack);
    checks++;
    if (ack !== 1'b1) $display("FAIL basic_addr_ack: sda_oe=%b required 1", ack); else passed++;
    checks++;
    if (addr_hit !== 1'b1) $display("FAIL basic_hit: addr_hit=%b required 1", addr_hit); else passed++;
    wait_clk(10);
    checks++;
    if (sda_oe !== 1'b0) $display("FAIL basic_release: sda_oe=%b required 0", sda_oe); else passed++;
    write_byte(8'hA5, ack);
    checks++;
    if (ack !== 1'b1) $display("FAIL basic_data_ack: sda_oe=%b required 1", ack); else passed++;
    i2c_stop();
    checks++;
    if ({addr_hit, bus_busy} !== 2'b00) $display("FAIL basic_stop: hit=%b busy=%b required 0 0", addr_hit, bus_busy);
    else passed++;
    consume(8'hA5, "basic");
  endtask

  task automatic test_no_ack(input logic [7:0] addr_byte, input string name);
    logic ack;
    oe_cnt = 0;
    i2c_start();
    write_byte(addr_byte, ack);
    checks++;
    if (ack !== 1'b0) $display("FAIL %s_addr_nack: sda_oe=%b required 0", name, ack); else passed++;
    write_byte(8'h5A, ack);
    checks++;
    if (ack !== 1'b0) $display("FAIL %s_data_nack: sda_oe=%b required 0", name, ack); else passed++;
    checks++;
    if (addr_hit !== 1'b0) $display("FAIL %s_hit: addr_hit=%b required 0", name, addr_hit); else passed++;
    i2c_stop();
    checks++;
    if ({bus_busy, rx_valid} !== 2'b00) $display("FAIL %s_idle: busy=%b valid=%b required 0 0", name, bus_busy, rx_valid);
    else passed++;
    checks++;
    if (oe_cnt !== 0) $display("FAIL %s_oe_cycles: %0d required 0", name, oe_cnt); else passed++;
  endtask

  task automatic test_overrun();
    logic ack;
    rx_ready = 1'b0;
    i2c_start();
    write_byte({7'h42, 1'b0}, ack);
    write_byte(8'h11, ack);
    checks++;
    if (ack !== 1'b1) $display("FAIL ovr_first_ack: sda_oe=%b required 1", ack); else passed++;
    ovr_cnt = 0;
    write_byte(8'h22, ack);
    checks++;
    if (ack !== 1'b0) $display("FAIL ovr_second_nack: sda_oe=%b required 0", ack); else passed++;
    checks++;
    if (ovr_cnt !== 1) $display("FAIL ovr_pulse: %0d cycles required 1", ovr_cnt); else passed++;
    write_byte(8'h33, ack);
    checks++;
    if (ack !== 1'b0 || ovr_cnt !== 1) $display("FAIL ovr_ignore: ack=%b pulses=%0d required 0 1", ack, ovr_cnt);
    else passed++;
    i2c_stop();
    consume(8'h11, "ovr");
  endtask

  task automatic test_repeated_start();
    logic ack;
    logic [7:0] first;
    first = 8'($urandom);
    i2c_start();
    write_byte({7'h42, 1'b0}, ack);
    write_byte(first, ack);
    consume(first, "rs_first");
    i2c_rep_start();
    checks++;
    if ({addr_hit, bus_busy} !== 2'b01) $display("FAIL rs_restart: hit=%b busy=%b required 0 1", addr_hit, bus_busy);
    else passed++;
    write_byte({7'h42, 1'b0}, ack);
    checks++;
    if (ack !== 1'b1) $display("FAIL rs_addr_ack: sda_oe=%b required 1", ack); else passed++;
    write_byte(8'h7E, ack);
    checks++;
    if (ack !== 1'b1) $display("FAIL rs_data_ack: sda_oe=%b required 1", ack); else passed++;
    i2c_stop();
    consume(8'h7E, "rs_second");
  endtask

  task automatic test_reset_mid();
    logic ack;
    i2c_start();
    write_byte({7'h42, 1'b0}, ack);
    write_byte(8'h5A, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1, ack);
    rst = 1'b1; #1;
    checks++;
    if ({sda_oe, rx_valid, addr_hit, bus_busy, overrun, rx_data} !== 13'h0)
      $display("FAIL midrst_outputs: oe=%b v=%b hit=%b busy=%b ovr=%b data=%h required all 0",
               sda_oe, rx_valid, addr_hit, bus_busy, overrun, rx_data);
    else passed++;
    m_valid = 1'b0;
    wait_clk(2); sda_m = 1'b1; wait_clk(2); scl_m = 1'b1; wait_clk(10);
    rst = 1'b0; wait_clk(10);
    i2c_start();
    write_byte({7'h42, 1'b0}, ack);
    checks++;
    if (ack !== 1'b1) $display("FAIL midrst_addr_ack: sda_oe=%b required 1", ack); else passed++;
    write_byte(8'h3C, ack);
    checks++;
    if (ack !== 1'b1) $display("FAIL midrst_data_ack: sda_oe=%b required 1", ack); else passed++;
    i2c_stop();
    consume(8'h3C, "midrst");
  endtask

  task automatic test_random();
    logic       ack, match, ign;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] d;
    int         nbytes, exp_ovr;
    for (int t = 0; t < 4; t++) begin
      addr    = ($urandom_range(0, 1) == 1) ? 7'h42 : 7'($urandom);
      rw      = ($urandom_range(0, 3) == 0);
      nbytes  = $urandom_range(1, 2);
      match   = (addr == 7'h42) && (rw == 1'b0);
      ign     = !match;
      exp_ovr = 0;
      ovr_cnt = 0;
      i2c_start();
      write_byte({addr, rw}, ack);
      checks++;
      if (ack !== match) $display("FAIL rnd%0d_addr: ack=%b required %b (addr %h rw %b)", t, ack, match, addr, rw);
      else passed++;
      for (int b = 0; b < nbytes; b++) begin
        logic exp_ack;
        d = 8'($urandom);
        exp_ack = 1'b0;
        if (!ign) begin
          if (!m_valid) begin m_valid = 1'b1; m_data = d; exp_ack = 1'b1; end
          else begin ign = 1'b1; exp_ovr++; end
        end
        write_byte(d, ack);
        checks++;
        if (ack !== exp_ack || ovr_cnt !== exp_ovr)
          $display("FAIL rnd%0d_byte%0d: ack=%b ovr=%0d required %b %0d", t, b, ack, ovr_cnt, exp_ack, exp_ovr);
        else passed++;
        if (m_valid && $urandom_range(0, 1) == 1) consume(m_data, "rnd_mid");
      end
      i2c_stop();
      checks++;
      if (rx_valid !== m_valid) $display("FAIL rnd%0d_valid: rx_valid=%b required %b", t, rx_valid, m_valid);
      else passed++;
      if (m_valid) consume(m_data, "rnd_end");
    end
  endtask

`ifdef I2C_GLITCH_FILTER_EN
  task automatic test_glitch();
    scl_m = 1'b1; sda_m = 1'b1; wait_clk(20);
    sda_m = 1'b0; wait_clk(2); sda_m = 1'b1; wait_clk(50);
    checks++;
    if ({bus_busy, addr_hit, sda_oe} !== 3'b000)
      $display("FAIL glitch: busy=%b hit=%b oe=%b required 0 0 0", bus_busy, addr_hit, sda_oe);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_write();
    test_no_ack({7'h43, 1'b0}, "wrong_addr");
    test_no_ack({7'h42, 1'b1}, "read");
    test_overrun();
    test_repeated_start();
    test_reset_mid();
    test_random();
`ifdef I2C_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- I2C target (subordinate) write-receiver. Oversamples the SCL/SDA pins on the 100 MHz system clock.
- Detects START, repeated START and STOP. Matches a 7-bit address and shifts in data bytes.
- Drives ACK/NACK on SDA through an open-drain enable.
- Sits at the far end of the 400 kHz SCL produced by the master-side clock generator. Hands received bytes to fabric over a valid/ready interface.

Parameters:
- ADDR, 7'h42, own 7-bit target address.
- SYNC_STAGES, 2, flops in each pin synchroniser (min 2).
- FILTER_LEN, 4, consecutive equal samples required by the glitch filter. Only used when I2C_GLITCH_FILTER_EN is defined.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous active-high reset
- scl_in  in  1  SCL pin level
- sda_in  in  1  SDA pin level
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release
- rx_data  out  8  last accepted data byte
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready
- addr_hit  out  1  high from a matching address ACK until STOP or repeated START
- bus_busy  out  1  high from START to STOP
- overrun  out  1  1-clk pulse: byte arrived while rx_valid still pending

Behaviour:
- Reset (async, immediate):
  - sda_oe=0, rx_data=0, rx_valid=0, addr_hit=0, bus_busy=0, overrun=0.
  - FSM=IDLE, bit counter=0.
  - Synchronisers load 1.
- Pin conditioning:
  - SCL and SDA pass through SYNC_STAGES flops, then a 1-flop edge detector.
  - Pin edge to internal event latency = SYNC_STAGES+1 clk (3 by default).
- Bus events (evaluated every clk, priority STOP > START > SCL edges):
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - Any state, START: go to ADDR, bit counter=0, bus_busy=1, addr_hit=0, sda_oe=0.
  - Any state, STOP: go to IDLE, bus_busy=0, addr_hit=0, sda_oe=0.
  - ADDR: on each SCL rise, shift the SDA sample in MSB-first. After 8 bits, on the next SCL fall:
    - addr[7:1]==ADDR and R/W=0: sda_oe=1 (ACK), addr_hit=1, go to ADDR_ACK.
    - Otherwise: sda_oe stays 0 (NACK), go to IGNORE.
  - ADDR_ACK: on the next SCL fall, sda_oe=0, go to DATA.
  - DATA: shift 8 bits on SCL rises. On the SCL fall after bit 8:
    - rx_valid=0 (or rx_ready high this clk): rx_data<=byte, rx_valid=1, sda_oe=1, go to DATA_ACK.
    - rx_valid=1 and rx_ready=0: byte discarded, overrun pulses 1 clk, sda_oe=0 (NACK), go to IGNORE.
  - DATA_ACK: on the next SCL fall, sda_oe=0, go to DATA (multi-byte writes unbounded).
  - IGNORE: sda_oe=0; wait for START or STOP.
- SDA transitions while SCL is high that are not START/STOP: only from the target's own sda_oe changes, which always occur after SCL falls.
- rx_valid clears on the clk where rx_valid & rx_ready. A simultaneous new byte reloads rx_data and keeps rx_valid=1.
- Bit counter is 3 bits wide and wraps 7 to 0 at byte end.
- A STOP or START arriving mid-byte aborts the partial byte; no rx_valid is raised.
- Reset asserted mid-transfer releases SDA in the same cycle (asynchronous).

Optional Feature:
- Macro I2C_GLITCH_FILTER_EN.
- Defined: each synchronised pin feeds a filter; the filtered level changes only after FILTER_LEN identical consecutive samples. Total latency becomes SYNC_STAGES+FILTER_LEN+1 clk. Pulses shorter than FILTER_LEN clk (40 ns) are suppressed.
- Undefined: filter absent; synchroniser output drives the edge detector directly.

Decomposition:
- Package i2c_pkg:
  - typedef enum i2c_rx_state_t {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE}.
  - Constants I2C_RW_WRITE=1'b0, I2C_BYTE_BITS=8.
- Sub-module i2c_pin_cond: synchroniser + optional glitch filter + edge detect. Instantiated once for SCL and once for SDA. Outputs level, rise, fall.

Test Plan:
- Master model at 400 kHz (125 clk half-period). START, addr 0x42+W, byte 0xA5, STOP:
  - sda_oe high during the 9th SCL of the address and of the data byte.
  - rx_data=0xA5, rx_valid=1, addr_hit=1 then 0 after STOP.
- START, addr 0x43+W: no sda_oe assertion, addr_hit=0, no rx_valid, FSM returns to IDLE at STOP.
- Addr 0x42+R: NACK, IGNORE until STOP, rx_valid stays 0.
- Bytes 0x11, 0x22 with rx_ready=0: first ACKed, rx_data=0x11; second NACKed, overrun one pulse, rx_data remains 0x11.
- Repeated START after one byte, then addr 0x42+W, byte 0x7E: ACKed.
  - First byte delivered, partial state cleared.
  - rx_data=0x7E after rx_ready handshake.
- rst pulse during DATA bit 4: sda_oe=0 and all outputs at reset values immediately. Next START/addr/byte 0x3C is received normally.
- With I2C_GLITCH_FILTER_EN defined: a 20 ns SDA low glitch while SCL is high produces no START and no state change.
